// File: rtl/cdb_arbiter_if.sv
// Completion/CDB bundle between the FU pool, the CDB arbiter and the writeback consumer.
// master = FU pool plus CDB consumer, slave = arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ID_W       = 2
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_FU-1:0]        fu_complete_valid;
    logic [NUM_FU*DATA_W-1:0] fu_complete_data;
    logic [NUM_FU-1:0]        fu_complete_ready;
    logic                     cdb_valid;
    logic [DATA_W-1:0]        cdb_data;
    logic [ID_W-1:0]          cdb_fu_id;
    logic                     cdb_ready;
    logic [NUM_FU*CNT_W-1:0]  fifo_count;

    modport master (
        output fu_complete_valid,
        output fu_complete_data,
        output cdb_ready,
        input  fu_complete_ready,
        input  cdb_valid,
        input  cdb_data,
        input  cdb_fu_id,
        input  fifo_count
    );

    modport slave (
        input  fu_complete_valid,
        input  fu_complete_data,
        input  cdb_ready,
        output fu_complete_ready,
        output cdb_valid,
        output cdb_data,
        output cdb_fu_id,
        output fifo_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-FU completion FIFOs feeding a round-robin arbiter that drives one record per cycle
// onto the common data bus.
module cdb_arbiter #(
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ID_W       = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q    [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_FU];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_FU];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_FU];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_FU];
    logic [CNT_W-1:0]  count_q  [NUM_FU];
    logic [CNT_W-1:0]  count_d  [NUM_FU];
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;

    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic              cdb_fire;

    // Scan from rr_ptr upward, wrapping; first non-empty FIFO wins.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = (k + 32'(rr_ptr_q)) % NUM_FU;
            if (!win_found && count_q[idx] != '0) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign cdb_fire = win_found && bus.cdb_ready;

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            // Ready looks only at the registered count, so a full FIFO bubbles for a cycle.
            bus.fu_complete_ready[i]             = (count_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]                              = bus.fu_complete_valid[i] &&
                                                   bus.fu_complete_ready[i];
            pop[i]                               = cdb_fire && (win_id == ID_W'(i));
            bus.fifo_count[i*CNT_W +: CNT_W]     = count_q[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end else begin
                if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
                count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (cdb_fire) begin
            rr_ptr_d = (win_id == ID_W'(NUM_FU - 1)) ? '0 : win_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage needs no reset; contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.fu_complete_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        bus.cdb_valid = win_found;
        bus.cdb_data  = win_found ? mem_q[win_id][rd_ptr_q[win_id]] : '0;
        bus.cdb_fu_id = win_found ? win_id : '0;
    end

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo_chk
        a_no_push_full: assert property (@(posedge clk) disable iff (rst)
            !(push[g] && count_q[g] == CNT_W'(FIFO_DEPTH)));
        a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
            !(pop[g] && count_q[g] == '0));
    end

    a_id_range: assert property (@(posedge clk) disable iff (rst)
        bus.cdb_valid |-> (32'(bus.cdb_fu_id) < NUM_FU));
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed check of cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int unsigned NumFu = 4;
    localparam int unsigned DataW = 64;
    localparam int unsigned Depth = 2;
    localparam int unsigned IdW   = 2;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(NumFu), .DATA_W(DataW), .FIFO_DEPTH(Depth), .ID_W(IdW)) bus ();

    cdb_arbiter #(.NUM_FU(NumFu), .DATA_W(DataW), .FIFO_DEPTH(Depth), .ID_W(IdW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mq [4][$];
    int          rr = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < 4; k++) begin
            int i = (rr + k) % 4;
            if (mq[i].size() != 0) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        rr = 0;
    endtask

    task automatic check_outputs();
        int          w = model_winner();
        logic [3:0]  er;
        logic [7:0]  ec;
        logic [63:0] ed;
        for (int i = 0; i < 4; i++) begin
            er[i]        = (mq[i].size() != Depth);
            ec[i*2 +: 2] = 2'(mq[i].size());
        end
        ed = (w >= 0) ? mq[w][0] : 64'd0;
        check_eq("cdb_valid", 64'(bus.cdb_valid), (w >= 0) ? 64'd1 : 64'd0);
        check_eq("cdb_data", bus.cdb_data, ed);
        check_eq("cdb_fu_id", 64'(bus.cdb_fu_id), (w >= 0) ? 64'(w) : 64'd0);
        check_eq("fu_ready", 64'(bus.fu_complete_ready), 64'(er));
        check_eq("fifo_count", 64'(bus.fifo_count), 64'(ec));
    endtask

    // Apply inputs for one cycle, check outputs mid-cycle, advance the model at the edge.
    task automatic drive(input logic [3:0] v, input logic [255:0] d, input logic rdy,
                         input logic fl);
        int w;
        int sz[4];
        bus.fu_complete_valid = v;
        bus.fu_complete_data  = d;
        bus.cdb_ready         = rdy;
        flush                 = fl;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        w = model_winner();
        for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
        if (fl) begin
            model_clear();
        end else begin
            if (w >= 0 && rdy) begin
                void'(mq[w].pop_front());
                rr = (w + 1) % 4;
            end
            for (int i = 0; i < 4; i++) begin
                if (v[i] && sz[i] != Depth) mq[i].push_back(d[i*64 +: 64]);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst                   = 1'b1;
        flush                 = 1'b0;
        bus.fu_complete_valid = '0;
        bus.fu_complete_data  = '0;
        bus.cdb_ready         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_valid", 64'(bus.cdb_valid), 64'd0);
        check_eq("async_ready", 64'(bus.fu_complete_ready), 64'hf);
        check_eq("async_count", 64'(bus.fifo_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    function automatic logic [255:0] pack4(input logic [63:0] a0, input logic [63:0] a1,
                                           input logic [63:0] a2, input logic [63:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    initial begin
        do_reset();

        // Idle after reset.
        check_eq("rst_ready", 64'(bus.fu_complete_ready), 64'hf);
        check_eq("rst_count", 64'(bus.fifo_count), 64'd0);
        repeat (2) drive(4'b0000, '0, 1'b1, 1'b0);

        // Single push from FU2.
        drive(4'b0100, pack4(0, 0, 64'hA5, 0), 1'b1, 1'b0);
        check_eq("single_data", bus.cdb_data, 64'hA5);
        check_eq("single_id", 64'(bus.cdb_fu_id), 64'd2);
        drive(4'b0000, '0, 1'b1, 1'b0);
        check_eq("single_idle", 64'(bus.cdb_valid), 64'd0);

        // Async reset between edges with a record buffered.
        drive(4'b0010, pack4(0, 64'h77, 0, 0), 1'b0, 1'b0);
        async_reset_check();

        // All four push together from rr_ptr = 0.
        drive(4'b1111, pack4(64'h10, 64'h11, 64'h12, 64'h13), 1'b1, 1'b0);
        check_eq("all4_first", 64'(bus.cdb_fu_id), 64'd0);
        repeat (5) drive(4'b0000, '0, 1'b1, 1'b0);

        // FU1 overfills its FIFO while the CDB is stalled.
        drive(4'b0010, pack4(0, 64'h101, 0, 0), 1'b0, 1'b0);
        drive(4'b0010, pack4(0, 64'h102, 0, 0), 1'b0, 1'b0);
        check_eq("full_ready1", 64'(bus.fu_complete_ready[1]), 64'd0);
        drive(4'b0010, pack4(0, 64'h103, 0, 0), 1'b0, 1'b0);
        drive(4'b0010, pack4(0, 64'h103, 0, 0), 1'b1, 1'b0);
        drive(4'b0010, pack4(0, 64'h103, 0, 0), 1'b1, 1'b0);
        check_eq("full_third", bus.cdb_data, 64'h103);
        repeat (2) drive(4'b0000, '0, 1'b1, 1'b0);

        // FU0 and FU3 continuously valid.
        for (int c = 0; c < 10; c++) begin
            drive(4'b1001, pack4(64'(c), 0, 0, 64'(100 + c)), 1'b1, 1'b0);
        end
        repeat (4) drive(4'b0000, '0, 1'b1, 1'b0);

        // Flush with FU0 x2 and FU2 x1 buffered plus a same-cycle FU1 push.
        do_reset();
        drive(4'b0101, pack4(64'h20, 0, 64'h22, 0), 1'b0, 1'b0);
        drive(4'b0001, pack4(64'h21, 0, 0, 0), 1'b0, 1'b0);
        drive(4'b0010, pack4(0, 64'h31, 0, 0), 1'b1, 1'b1);
        check_eq("flush_valid", 64'(bus.cdb_valid), 64'd0);
        check_eq("flush_count", 64'(bus.fifo_count), 64'd0);
        drive(4'b1010, pack4(0, 64'h41, 0, 64'h43), 1'b1, 1'b0);
        check_eq("flush_rr", 64'(bus.cdb_fu_id), 64'd1);
        repeat (3) drive(4'b0000, '0, 1'b1, 1'b0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            logic [255:0] d;
            for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
            drive(4'($urandom), d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
            if ($urandom_range(0, 150) == 0) async_reset_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
